// File: rtl/hardware_binarize_stream.sv
// -----------------------------------------------------------------------------
// hardware_binarize_stream
//
// Purpose:
//   Transmit-side encoder and byte serializer for combinator terms. A 63-bit
//   tagged term (3-bit tag, 60-bit payload) is accepted on a valid/ready
//   handshake. It is packed into a 64-bit wire word (4-bit tag nibble, then
//   payload) and shifted out as bytes on a second valid/ready handshake.
//   Terms with tags 5..7 cannot be encoded. They are accepted and dropped,
//   and err_o pulses for one cycle after acceptance.
//
// Parameters:
//   MSB_FIRST      1: word[63:56] is sent first; 0: word[7:0] is sent first.
//
// Build option:
//   BINARIZE_COMPACT_EN  when defined, nullary tags 0..2 are sent as a single
//                        byte {1'b0, tag, 4'h0} instead of a full 8-byte word.
//
// Ports:
//   system1000      in   clock, rising edge
//   system1000_rst  in   asynchronous reset, active high
//   term_i[62:0]    in   term: [62:60] tag, [59:0] payload
//   term_valid_i    in   term_i is valid
//   term_ready_o    out  term_i is accepted this cycle
//   byte_o[7:0]     out  current output byte
//   byte_valid_o    out  byte_o is valid
//   byte_ready_i    in   sink accepts byte_o this cycle
//   err_o           out  one-cycle pulse after an unencodable term is dropped
// -----------------------------------------------------------------------------
module hardware_binarize_stream #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic        system1000,
    input  logic        system1000_rst,
    input  logic [62:0] term_i,
    input  logic        term_valid_i,
    output logic        term_ready_o,
    output logic [7:0]  byte_o,
    output logic        byte_valid_o,
    input  logic        byte_ready_i,
    output logic        err_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] shreg_q, shreg_d;
    logic [2:0]  cnt_q,   cnt_d;
    logic        err_q,   err_d;

    // Encoder outputs for the term currently presented on term_i.
    logic [2:0]  tag;
    logic [63:0] enc_word;
    logic [2:0]  enc_cnt;
    logic        enc_ok;

    logic        term_ready;
    logic        term_accept;
    logic [7:0]  end_byte;
    logic [63:0] shreg_shifted;

    assign tag = term_i[62:60];

    // NOTE: every signal driven in an always_comb gets a default on entry;
    // any path that leaves it unassigned would infer a latch.
    always_comb begin
        enc_word = 64'h0;
        enc_cnt  = 3'd7;
        enc_ok   = 1'b1;
        unique case (tag)
            3'd0, 3'd1, 3'd2: begin
`ifdef BINARIZE_COMPACT_EN
                // The single byte must be at whichever end is sent first.
                if (MSB_FIRST) enc_word = {1'b0, tag, 4'h0, 56'h0};
                else           enc_word = {56'h0, 1'b0, tag, 4'h0};
                enc_cnt  = 3'd0;
`else
                enc_word = {1'b0, tag, 60'h0};
`endif
            end
            3'd3:    enc_word = {1'b0, tag, term_i[59:0]};
            // The 32-bit literal is taken from the top of the payload field.
            3'd4:    enc_word = {1'b0, tag, 28'h0, term_i[59:28]};
            default: enc_ok   = 1'b0;
        endcase
    end

    assign end_byte      = MSB_FIRST ? shreg_q[63:56] : shreg_q[7:0];
    assign shreg_shifted = MSB_FIRST ? {shreg_q[55:0], 8'h00}
                                     : {8'h00, shreg_q[63:8]};

    // Next-state logic and handshake outputs.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
        err_d        = 1'b0;
        term_ready   = 1'b0;
        byte_valid_o = 1'b0;

        unique case (state_q)
            IDLE: begin
                term_ready = 1'b1;
            end
            SHIFT: begin
                byte_valid_o = 1'b1;
                // A new term is taken only while the last byte is consumed,
                // so back-to-back words have no bubble between them.
                term_ready   = byte_ready_i && (cnt_q == 3'd0);
                if (byte_ready_i) begin
                    shreg_d = shreg_shifted;
                    if (cnt_q == 3'd0) state_d = IDLE;
                    else               cnt_d   = cnt_q - 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        term_accept = term_valid_i && term_ready;
        if (term_accept) begin
            if (enc_ok) begin
                shreg_d = enc_word;
                cnt_d   = enc_cnt;
                state_d = SHIFT;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // The reset gate keeps ready low for the whole reset assertion and lets
    // it rise as soon as reset is released.
    assign term_ready_o = term_ready && !system1000_rst;
    assign byte_o       = (state_q == SHIFT) ? end_byte : 8'h00;
    assign err_o        = err_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge.
    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            state_q <= IDLE;
            shreg_q <= 64'h0;
            cnt_q   <= 3'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_hardware_binarize_stream.sv
// -----------------------------------------------------------------------------
// tb_hardware_binarize_stream
//
// Directed bench for hardware_binarize_stream. Two instances share every
// input: dut_m sends MSB first, dut_l sends LSB first. Inputs are driven on
// the falling edge and outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_hardware_binarize_stream;

    logic        clk;
    logic        rst;
    logic [62:0] term;
    logic        term_valid;
    logic        byte_ready;

    logic        ready_m, valid_m, err_m;
    logic [7:0]  byte_m;
    logic        ready_l, valid_l, err_l;
    logic [7:0]  byte_l;

    int errors = 0;
    int checks = 0;

    hardware_binarize_stream #(.MSB_FIRST(1'b1)) dut_m (
        .system1000     (clk),
        .system1000_rst (rst),
        .term_i         (term),
        .term_valid_i   (term_valid),
        .term_ready_o   (ready_m),
        .byte_o         (byte_m),
        .byte_valid_o   (valid_m),
        .byte_ready_i   (byte_ready),
        .err_o          (err_m)
    );

    hardware_binarize_stream #(.MSB_FIRST(1'b0)) dut_l (
        .system1000     (clk),
        .system1000_rst (rst),
        .term_i         (term),
        .term_valid_i   (term_valid),
        .term_ready_o   (ready_l),
        .byte_o         (byte_l),
        .byte_valid_o   (valid_l),
        .byte_ready_i   (byte_ready),
        .err_o          (err_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Checks one byte cycle on both instances. w is the word in MSB-first
    // order; in a one-byte (compact) transfer both instances send w[63:56].
    task automatic check_byte(input string name, input logic [63:0] w, input int k, input int n);
        logic [7:0] exp_m, exp_l;
        exp_m = w[63 - 8*k -: 8];
        exp_l = (n == 1) ? w[63:56] : w[8*k +: 8];
        check({name, " valid_m"}, 64'(valid_m), 64'(1'b1));
        check({name, " valid_l"}, 64'(valid_l), 64'(1'b1));
        check($sformatf("%s byte_m[%0d]", name, k), 64'(byte_m), 64'(exp_m));
        check($sformatf("%s byte_l[%0d]", name, k), 64'(byte_l), 64'(exp_l));
    endtask

    // Presents a term, then checks every byte with the sink always ready.
    task automatic run_term(input string name, input logic [62:0] t,
                            input logic [63:0] w, input int n);
        @(negedge clk);
        term = t; term_valid = 1'b1; byte_ready = 1'b1;
        #1 check({name, " ready"}, 64'(ready_m & ready_l), 64'(1'b1));
        @(negedge clk);
        term_valid = 1'b0;
        term = '1;   // a later change must not affect the word being sent
        for (int k = 0; k < n; k++) begin
            #1 check_byte(name, w, k, n);
            @(negedge clk);
        end
        #1 check({name, " done valid"}, 64'(valid_m | valid_l), 64'(1'b0));
        check({name, " done ready"}, 64'(ready_m & ready_l), 64'(1'b1));
    endtask

    localparam logic [62:0] T3 = {3'b011, 30'h15555555, 30'h0ABCDEF0};
    localparam logic [63:0] W3 = 64'h35555555_4ABCDEF0;
    localparam logic [62:0] T4 = {3'd4, 32'hDEADBEEF, 28'hFFFFFFF};
    localparam logic [63:0] W4 = 64'h40000000_DEADBEEF;
    localparam logic [62:0] T1 = {3'd1, 60'h0};
    localparam logic [62:0] T0 = {3'd0, 60'h0};
    localparam logic [62:0] T6 = {3'd6, 60'hABCDEF012345678};
    localparam logic [62:0] T7 = {3'd7, 60'h123456789ABCDEF};
`ifdef BINARIZE_COMPACT_EN
    localparam logic [63:0] W1 = {8'h10, 56'h0};
    localparam int          N_NULL = 1;
`else
    localparam logic [63:0] W1 = 64'h10000000_00000000;
    localparam int          N_NULL = 8;
`endif

    initial begin
        rst = 1'b1; term = '0; term_valid = 1'b0; byte_ready = 1'b1;

        // Reset state.
        #2;
        check("rst ready",   64'(ready_m | ready_l), 64'(1'b0));
        check("rst valid",   64'(valid_m | valid_l), 64'(1'b0));
        check("rst byte_m",  64'(byte_m), 64'h0);
        check("rst byte_l",  64'(byte_l), 64'h0);
        check("rst err",     64'(err_m | err_l), 64'(1'b0));
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        #1 check("post-rst ready", 64'(ready_m & ready_l), 64'(1'b1));

        // Main encodings.
        run_term("tag3", T3, W3, 8);
        run_term("tag4", T4, W4, 8);
        run_term("tag1", T1, W1, N_NULL);

        // Invalid tag: dropped, err for exactly one cycle.
        @(negedge clk);
        term = T6; term_valid = 1'b1;
        #1 check("tag6 ready", 64'(ready_m & ready_l), 64'(1'b1));
        @(negedge clk);
        term_valid = 1'b0;
        #1 check("tag6 err",   64'({err_m, err_l}), 64'(2'b11));
        check("tag6 valid",    64'(valid_m | valid_l), 64'(1'b0));
        check("tag6 ready2",   64'(ready_m & ready_l), 64'(1'b1));
        @(negedge clk);
        #1 check("tag6 err off", 64'(err_m | err_l), 64'(1'b0));
        check("tag6 valid2",   64'(valid_m | valid_l), 64'(1'b0));

        // Backpressure on byte 2 for three cycles.
        @(negedge clk);
        term = T3; term_valid = 1'b1;
        @(negedge clk);
        term_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k == 2) begin
                byte_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    #1 check_byte("stall", W3, 2, 8);
                    check("stall ready", 64'(ready_m | ready_l), 64'(1'b0));
                    @(negedge clk);
                end
                byte_ready = 1'b1;
            end
            #1 check_byte("bp", W3, k, 8);
            @(negedge clk);
        end
        #1 check("bp done valid", 64'(valid_m | valid_l), 64'(1'b0));

        // Back-to-back: second term waits and is taken on the last byte.
        @(negedge clk);
        term = T3; term_valid = 1'b1;
        @(negedge clk);
        term = T4;
        for (int k = 0; k < 8; k++) begin
            #1 check_byte("b2b A", W3, k, 8);
            check($sformatf("b2b ready[%0d]", k), 64'(ready_m & ready_l), 64'(k == 7));
            @(negedge clk);
        end
        term_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1 check_byte("b2b B", W4, k, 8);
            @(negedge clk);
        end
        #1 check("b2b done valid", 64'(valid_m | valid_l), 64'(1'b0));

        // Invalid tag accepted on the last-byte cycle.
        @(negedge clk);
        term = T4; term_valid = 1'b1;
        @(negedge clk);
        term = T7;
        for (int k = 0; k < 8; k++) begin
            #1 check_byte("lastinv", W4, k, 8);
            @(negedge clk);
        end
        term_valid = 1'b0;
        #1 check("lastinv err",   64'({err_m, err_l}), 64'(2'b11));
        check("lastinv valid",    64'(valid_m | valid_l), 64'(1'b0));
        check("lastinv ready",    64'(ready_m & ready_l), 64'(1'b1));
        @(negedge clk);
        #1 check("lastinv err off", 64'(err_m | err_l), 64'(1'b0));

        // Reset in the middle of a word.
        @(negedge clk);
        term = T3; term_valid = 1'b1;
        @(negedge clk);
        term_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1 check_byte("midrst", W3, k, 8);
            @(negedge clk);
        end
        #1 rst = 1'b1;
        #1 check("midrst valid", 64'(valid_m | valid_l), 64'(1'b0));
        check("midrst byte",     64'({byte_m, byte_l}), 64'h0);
        check("midrst ready",    64'(ready_m | ready_l), 64'(1'b0));
        @(negedge clk);
        rst = 1'b0;
        #1 check("midrst idle valid", 64'(valid_m | valid_l), 64'(1'b0));
        check("midrst idle ready",    64'(ready_m & ready_l), 64'(1'b1));
        run_term("tag0", T0, 64'h0, N_NULL);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
